// File: rtl/spectrum_pkg.sv
// spectrum_pkg: shared defaults, reset coefficients and sequencer state type for the band filter sequencer.
package spectrum_pkg;
    localparam int NUM_BANDS_DEF     = 4;
    localparam int ENERGY_BITS_DEF   = 8;
    localparam int ENERGY_WINDOW_DEF = 16;
    // Band b coefficient lives in bits [8*b +: 8]; bands past the table shift in zeros.
    localparam logic [31:0] COEF_A_RST = {8'd5, 8'd10, 8'd15, 8'd20};
    localparam logic [31:0] COEF_B_RST = {8'd40, 8'd30, 8'd25, 8'd10};

    typedef enum logic [2:0] {IDLE, MUL_A, MUL_B, UPDATE, FINISH} seq_state_t;

    function automatic logic [7:0] abs8(input logic signed [7:0] v);
        return v[7] ? 8'(-v) : 8'(v);
    endfunction
endpackage

// File: rtl/band_filter_sequencer_if.sv
// band_filter_sequencer_if: sampler, coefficient-config and band-energy bus of the band filter sequencer.
interface band_filter_sequencer_if import spectrum_pkg::*; #(
    parameter int NUM_BANDS   = NUM_BANDS_DEF,
    parameter int ENERGY_BITS = ENERGY_BITS_DEF
);
    logic                              sample_strobe;
    logic signed [7:0]                 audio_sample;
    logic                              cfg_we;
    logic [$clog2(2*NUM_BANDS)-1:0]    cfg_addr;
    logic signed [7:0]                 cfg_data;
    logic                              cfg_ready;
    logic                              busy;
    logic                              done;
    logic                              energy_valid;
    logic [NUM_BANDS*ENERGY_BITS-1:0]  band_energy;
    logic                              overrun;
    logic                              ovr_clr;

    modport master (
        output sample_strobe, audio_sample, cfg_we, cfg_addr, cfg_data, ovr_clr,
        input  cfg_ready, busy, done, energy_valid, band_energy, overrun
    );
    modport slave (
        input  sample_strobe, audio_sample, cfg_we, cfg_addr, cfg_data, ovr_clr,
        output cfg_ready, busy, done, energy_valid, band_energy, overrun
    );
endinterface

// File: rtl/filter_mac.sv
// filter_mac: shared signed 8x16 multiply, arithmetic >>>8 scaling, truncated to 16 bits.
module filter_mac (
    input  logic signed [7:0]  coef,
    input  logic signed [15:0] operand,
    output logic signed [15:0] result
);
    logic signed [23:0] prod;
    assign prod   = 24'(coef) * 24'(operand);
    assign result = prod[23:8];
endmodule

// File: rtl/band_filter_sequencer.sv
// band_filter_sequencer: runs every band IIR through one shared MAC per audio sample and integrates band energy.
// Define FILTER_SAT_EN to saturate state, accumulator and energy sums instead of wrapping.
module band_filter_sequencer import spectrum_pkg::*; #(
    parameter int NUM_BANDS     = NUM_BANDS_DEF,
    parameter int ENERGY_WINDOW = ENERGY_WINDOW_DEF,
    parameter int ENERGY_BITS   = ENERGY_BITS_DEF
) (
    input logic clk,
    input logic rst,
    band_filter_sequencer_if.slave bus
);
    localparam int BW = NUM_BANDS > 1 ? $clog2(NUM_BANDS) : 1;
    localparam int WW = ENERGY_WINDOW > 1 ? $clog2(ENERGY_WINDOW) : 1;
    localparam int AW = $clog2(2*NUM_BANDS);

    seq_state_t              state;
    logic [BW-1:0]           band;
    logic [WW-1:0]           win_cnt;
    logic signed [7:0]       x;
    logic signed [15:0]      t_a, t_b, mac_y, mac_v, s_next;
    logic signed [7:0]       mac_c;
    logic signed [7:0]       coef_a [NUM_BANDS];
    logic signed [7:0]       coef_b [NUM_BANDS];
    logic signed [15:0]      s_q [NUM_BANDS];
    logic signed [15:0]      o_q [NUM_BANDS];
    logic [ENERGY_BITS-1:0]  acc [NUM_BANDS];
    logic [ENERGY_BITS-1:0]  energy [NUM_BANDS];
    logic [ENERGY_BITS-1:0]  e_next [NUM_BANDS];
    logic [ENERGY_BITS-1:0]  acc_next;
    logic                    busy, done, energy_valid, overrun;

    assign mac_c = state == MUL_A ? coef_a[band] : coef_b[band];
    assign mac_v = state == MUL_A ? o_q[band] : 16'(x);

    filter_mac u_mac (.coef(mac_c), .operand(mac_v), .result(mac_y));

`ifdef FILTER_SAT_EN
    logic signed [17:0]     s_sum;
    logic [ENERGY_BITS:0]   acc_sum;
    logic [ENERGY_BITS:0]   e_sum [NUM_BANDS];
    assign s_sum    = 18'(s_q[band]) - 18'(t_a) + 18'(t_b);
    assign s_next   = s_sum > 18'sd32767 ? 16'sh7fff : s_sum < -18'sd32768 ? 16'sh8000 : s_sum[15:0];
    assign acc_sum  = (ENERGY_BITS+1)'(acc[band]) + (ENERGY_BITS+1)'(abs8(s_q[band][15:8]));
    assign acc_next = acc_sum[ENERGY_BITS] ? '1 : acc_sum[ENERGY_BITS-1:0];
    always_comb begin
        for (int b = 0; b < NUM_BANDS; b++) begin
            e_sum[b]  = (ENERGY_BITS+1)'(energy[b] >> 1) + (ENERGY_BITS+1)'(acc[b] >> 1);
            e_next[b] = e_sum[b][ENERGY_BITS] ? '1 : e_sum[b][ENERGY_BITS-1:0];
        end
    end
`else
    assign s_next   = s_q[band] - t_a + t_b;
    assign acc_next = acc[band] + ENERGY_BITS'(abs8(s_q[band][15:8]));
    always_comb begin
        for (int b = 0; b < NUM_BANDS; b++) begin
            e_next[b] = (energy[b] >> 1) + (acc[b] >> 1);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            band         <= '0;
            win_cnt      <= '0;
            x            <= '0;
            t_a          <= '0;
            t_b          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            energy_valid <= 1'b0;
            overrun      <= 1'b0;
            for (int b = 0; b < NUM_BANDS; b++) begin
                coef_a[b] <= 8'(COEF_A_RST >> (8*b));
                coef_b[b] <= 8'(COEF_B_RST >> (8*b));
                s_q[b]    <= '0;
                o_q[b]    <= '0;
                acc[b]    <= '0;
                energy[b] <= '0;
            end
        end else begin
            done         <= 1'b0;
            energy_valid <= 1'b0;
            // A dropped strobe must win over a simultaneous clear.
            overrun      <= (bus.sample_strobe && busy) || (overrun && !bus.ovr_clr);
            if (bus.cfg_we && !busy && 32'(bus.cfg_addr) < 2*NUM_BANDS) begin
                if (bus.cfg_addr[0]) coef_b[bus.cfg_addr[AW-1:1]] <= bus.cfg_data;
                else coef_a[bus.cfg_addr[AW-1:1]] <= bus.cfg_data;
            end
            case (state)
                IDLE: if (bus.sample_strobe) begin
                    x     <= bus.audio_sample;
                    band  <= '0;
                    busy  <= 1'b1;
                    state <= MUL_A;
                end
                MUL_A: begin
                    t_a   <= mac_y;
                    state <= MUL_B;
                end
                MUL_B: begin
                    t_b   <= mac_y;
                    state <= UPDATE;
                end
                UPDATE: begin
                    s_q[band] <= s_next;
                    o_q[band] <= s_q[band];
                    acc[band] <= acc_next;
                    if (band == BW'(NUM_BANDS-1)) begin
                        state        <= FINISH;
                        done         <= 1'b1;
                        energy_valid <= win_cnt == WW'(ENERGY_WINDOW-1);
                    end else begin
                        band  <= band + 1'b1;
                        state <= MUL_A;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (energy_valid) begin
                        win_cnt <= '0;
                        for (int b = 0; b < NUM_BANDS; b++) begin
                            energy[b] <= e_next[b];
                            acc[b]    <= '0;
                        end
                    end else begin
                        win_cnt <= win_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy         = busy;
    assign bus.cfg_ready    = !busy;
    assign bus.done         = done;
    assign bus.energy_valid = energy_valid;
    assign bus.overrun      = overrun;

    for (genvar b = 0; b < NUM_BANDS; b++) begin : g_energy
        assign bus.band_energy[b*ENERGY_BITS +: ENERGY_BITS] = energy[b];
    end
endmodule
